// File: rtl/servo_ramp_ctrl.sv
// rtl/servo_ramp_ctrl.sv - servo PWM pulsewidth sequencer with clamped slew-limited ramp and settle hold
module servo_ramp_ctrl #(
  parameter int W           = 12,
  parameter int PERIOD      = 2000,
  parameter int PW_MIN      = 100,
  parameter int PW_MAX      = 200,
  parameter int STEP        = 1,
  parameter int HOLD_FRAMES = 50
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         enable,
  input  logic [W-1:0] cmd_pw,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  output logic         pwm_en,
  output logic [W-1:0] pulsewidth,
  output logic         frame_tick,
  output logic         busy,
  output logic         at_target
);

  localparam int FW = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam int HW = (HOLD_FRAMES > 1) ? $clog2(HOLD_FRAMES + 1) : 1;

  localparam logic [FW-1:0] LP_CNT_LAST  = FW'(PERIOD - 1);
  localparam logic [FW-1:0] LP_CNT_PRE   = FW'(PERIOD - 2);
  localparam logic [W-1:0]  LP_PW_MIN    = W'(PW_MIN);
  localparam logic [W-1:0]  LP_PW_MAX    = W'(PW_MAX);
  localparam logic [W-1:0]  LP_PW_MID    = W'((PW_MIN + PW_MAX) / 2);
  localparam logic [W:0]    LP_STEP      = (W + 1)'(STEP);
  localparam logic [HW-1:0] LP_HOLD_LAST = HW'(HOLD_FRAMES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RAMP,
    S_HOLD
  } state_t;

  state_t          r_state;
  state_t          w_state_n;
  logic [FW-1:0]   r_frame_cnt;
  logic            r_frame_tick;
  logic            r_pwm_en;
  logic [HW-1:0]   r_hold_cnt;
  logic [HW-1:0]   w_hold_n;
  logic [W-1:0]    r_pw;
  logic [W-1:0]    w_pw_n;
  logic [W-1:0]    r_target;
  logic [W-1:0]    w_target_n;

  logic            w_ready;
  logic            w_accept;
  logic [W-1:0]    w_clamp;
  logic [W:0]      w_diff;
  logic [W:0]      w_mag;
  logic            w_down;
  logic [W-1:0]    w_step;
  logic [W-1:0]    w_pw_stepped;

  // Frame timebase: the tick register is loaded one count early so it is high on the last cycle of the frame
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_frame_cnt  <= '0;
      r_frame_tick <= 1'b0;
      r_pwm_en     <= 1'b0;
    end else begin
      r_pwm_en <= enable;
      if (!enable) begin
        r_frame_cnt  <= '0;
        r_frame_tick <= 1'b0;
      end else begin
        r_frame_cnt  <= (r_frame_cnt == LP_CNT_LAST) ? '0 : r_frame_cnt + 1'b1;
        r_frame_tick <= (r_frame_cnt == LP_CNT_PRE);
      end
    end
  end

  // Command clamp and slew step; the signed difference needs one extra bit
  always_comb begin
    w_clamp = cmd_pw;
    if (cmd_pw < LP_PW_MIN) begin
      w_clamp = LP_PW_MIN;
    end else if (cmd_pw > LP_PW_MAX) begin
      w_clamp = LP_PW_MAX;
    end
    w_diff       = {1'b0, r_target} - {1'b0, r_pw};
    w_down       = w_diff[W];
    w_mag        = w_down ? (~w_diff + 1'b1) : w_diff;
    w_step       = (w_mag < LP_STEP) ? w_mag[W-1:0] : LP_STEP[W-1:0];
    w_pw_stepped = w_down ? (r_pw - w_step) : (r_pw + w_step);
  end

  assign w_ready  = rst_n && enable && (r_state != S_RAMP);
  assign w_accept = cmd_valid && w_ready;

  // Next-state logic: disable wins, then an accepted command, then frame-tick driven progress
  always_comb begin
    w_state_n  = r_state;
    w_hold_n   = r_hold_cnt;
    w_pw_n     = r_pw;
    w_target_n = r_target;
    if (!enable) begin
      w_state_n = S_IDLE;
      w_hold_n  = '0;
    end else if (w_accept) begin
      w_target_n = w_clamp;
      w_hold_n   = '0;
      w_state_n  = (w_clamp == r_pw) ? S_HOLD : S_RAMP;
    end else if (r_frame_tick) begin
      case (r_state)
        S_RAMP: begin
          w_pw_n = w_pw_stepped;
          if (w_pw_stepped == r_target) begin
            w_state_n = S_HOLD;
            w_hold_n  = '0;
          end
        end
        S_HOLD: begin
          if (r_hold_cnt == LP_HOLD_LAST) begin
            w_state_n = S_IDLE;
            w_hold_n  = '0;
          end else begin
            w_hold_n = r_hold_cnt + 1'b1;
          end
        end
        default: begin
          w_state_n = r_state;
        end
      endcase
    end
  end

  // Sequencer state register; reset parks the servo at mid travel
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_hold_cnt <= '0;
      r_pw       <= LP_PW_MID;
      r_target   <= LP_PW_MID;
    end else begin
      r_state    <= w_state_n;
      r_hold_cnt <= w_hold_n;
      r_pw       <= w_pw_n;
      r_target   <= w_target_n;
    end
  end

  assign cmd_ready  = w_ready;
  assign pwm_en     = r_pwm_en;
  assign pulsewidth = r_pw;
  assign frame_tick = r_frame_tick;
  assign busy       = (r_state != S_IDLE);
  assign at_target  = (r_pw == r_target) && (r_state != S_RAMP);

endmodule
